// File: rtl/vending_pkg.sv
// Shared encodings and defaults for the vending machine change path.
// Main-state and change-state enums plus default coin denominations.
package vending_pkg;

    localparam int W_MONEY  = 5;
    localparam int DEN0_DEF = 10;
    localparam int DEN1_DEF = 5;
    localparam int DEN2_DEF = 2;
    localparam int DEN3_DEF = 1;

    typedef enum logic [2:0] {
        MS_WAIT     = 3'd0,
        MS_INSERTED = 3'd1,
        MS_INVALID  = 3'd2,
        MS_VALID    = 3'd3,
        MS_THANKS   = 3'd4
    } main_state_e;

    typedef enum logic [1:0] {
        CS_IDLE   = 2'd0,
        CS_PAY    = 2'd1,
        CS_DONE   = 2'd2,
        CS_UNUSED = 2'd3
    } change_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the main vending FSM (master) and the change dispenser
// (slave): state/money in, coin stream and completion flag out.
interface change_dispenser_if #(
    parameter int W = vending_pkg::W_MONEY
);
    logic [2:0]   mainState;
    logic [W-1:0] inputMoney;
    logic [W-1:0] valueToPay;
    logic         noMoneyLeft;
    logic         coinValid;
    logic [W-1:0] coinOut;
    logic [W-1:0] remaining;
    logic [1:0]   changeState;

    modport master (
        output mainState, inputMoney, valueToPay,
        input  noMoneyLeft, coinValid, coinOut, remaining, changeState
    );

    modport slave (
        input  mainState, inputMoney, valueToPay,
        output noMoneyLeft, coinValid, coinOut, remaining, changeState
    );
endinterface

// File: rtl/coin_selector.sv
// Greedy denomination pick: largest coin not exceeding the amount.
// Purely combinational; returns 0 when nothing is left to pay.
module coin_selector #(
    parameter int W    = vending_pkg::W_MONEY,
    parameter int DEN0 = vending_pkg::DEN0_DEF,
    parameter int DEN1 = vending_pkg::DEN1_DEF,
    parameter int DEN2 = vending_pkg::DEN2_DEF,
    parameter int DEN3 = vending_pkg::DEN3_DEF
) (
    input  logic [W-1:0] i_amount,
    output logic [W-1:0] o_coin
);
    always_comb begin
        o_coin = '0;
        if (i_amount >= W'(DEN0))
            o_coin = W'(DEN0);
        else if (i_amount >= W'(DEN1))
            o_coin = W'(DEN1);
        else if (i_amount >= W'(DEN2))
            o_coin = W'(DEN2);
        else if (i_amount >= W'(DEN3))
            o_coin = W'(DEN3);
    end
endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: loads the refund/change amount from the main FSM and
// pays it out one greedy coin per clock, then flags completion.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int W    = W_MONEY,
    parameter int DEN0 = DEN0_DEF,
    parameter int DEN1 = DEN1_DEF,
    parameter int DEN2 = DEN2_DEF,
    parameter int DEN3 = DEN3_DEF
) (
    input  logic               clock,
    input  logic               reset,
    change_dispenser_if.slave  bus
);
    change_state_e r_state, w_state;
    logic [W-1:0]  r_rem, w_rem;
    logic [W-1:0]  r_coin, w_coin;
    logic          r_valid, w_valid;
    logic          r_nml, w_nml;
    logic [W-1:0]  w_den;
    logic [W:0]    w_diff;
    logic          w_pay_ms;

    coin_selector #(
        .W(W), .DEN0(DEN0), .DEN1(DEN1), .DEN2(DEN2), .DEN3(DEN3)
    ) u_sel (
        .i_amount (r_rem),
        .o_coin   (w_den)
    );

    // Extra bit catches a price above the inserted amount
    assign w_diff   = {1'b0, bus.inputMoney} - {1'b0, bus.valueToPay};
    assign w_pay_ms = (bus.mainState == MS_INVALID) ||
                      (bus.mainState == MS_VALID);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CS_IDLE;
            r_rem   <= '0;
            r_coin  <= '0;
            r_valid <= 1'b0;
            r_nml   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_coin  <= w_coin;
            r_valid <= w_valid;
            r_nml   <= w_nml;
        end
    end

    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_coin  = '0;
        w_valid = 1'b0;
        w_nml   = r_nml;
        unique case (r_state)
            CS_IDLE: begin
                w_nml = 1'b0;
                if (bus.mainState == MS_VALID) begin
                    w_rem   = w_diff[W] ? '0 : w_diff[W-1:0];
                    w_state = CS_PAY;
                end else if (bus.mainState == MS_INVALID) begin
                    w_rem   = bus.inputMoney;
                    w_state = CS_PAY;
                end
            end
            CS_PAY: begin
                if (!w_pay_ms) begin
                    w_rem   = '0;
                    w_nml   = 1'b0;
                    w_state = CS_IDLE;
                end else if (r_rem == '0) begin
                    w_nml   = 1'b1;
                    w_state = CS_DONE;
                end else begin
                    w_valid = 1'b1;
                    w_coin  = w_den;
                    w_rem   = r_rem - w_den;
                end
            end
            CS_DONE: begin
                if (!w_pay_ms) begin
                    w_nml   = 1'b0;
                    w_rem   = '0;
                    w_state = CS_IDLE;
                end
            end
            default: begin
                w_nml   = 1'b0;
                w_rem   = '0;
                w_state = CS_IDLE;
            end
        endcase
    end

    assign bus.noMoneyLeft = r_nml;
    assign bus.coinValid   = r_valid;
    assign bus.coinOut     = r_coin;
    assign bus.remaining   = r_rem;
    assign bus.changeState = r_state;
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of payouts checked
// through a coin scoreboard, plus reset/abort sequences.
module tb_change_dispenser;
    import vending_pkg::*;

    typedef struct {
        logic [2:0]       ms;
        logic [4:0]       in;
        logic [4:0]       price;
        logic [4:0]       newin;
        logic [4:0]       total;
        int               n;
        logic [3:0][4:0]  c;
    } vec_t;

    typedef struct {
        logic [4:0] coin;
        logic [4:0] rem;
    } exp_t;

    logic clock;
    logic reset;
    bit   mon_en;
    int   n_cmp;
    int   n_err;
    exp_t q[$];
    vec_t tbl[8];

    change_dispenser_if #(.W(5)) bus();

    change_dispenser dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] ms, input int in,
                                input int price, input int newin,
                                input int total, input int n,
                                input int c0, input int c1,
                                input int c2, input int c3);
        vec_t v;
        v.ms    = ms;
        v.in    = 5'(in);
        v.price = 5'(price);
        v.newin = 5'(newin);
        v.total = 5'(total);
        v.n     = n;
        v.c[0]  = 5'(c0);
        v.c[1]  = 5'(c1);
        v.c[2]  = 5'(c2);
        v.c[3]  = 5'(c3);
        return v;
    endfunction

    // Coin scoreboard: every dispensed coin must match the next expectation
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.coinValid === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_coin: got %0d expected none",
                             bus.coinOut);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("coin", bus.coinOut, e.coin);
                    chk("coin_rem", bus.remaining, e.rem);
                end
            end else begin
                chk("idle_coin", bus.coinOut, 0);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   tot;
        int   cyc;
        logic seen;
        exp_t e;
        tot = v.total;
        for (int i = 0; i < v.n; i++) begin
            tot    = tot - v.c[i];
            e.coin = v.c[i];
            e.rem  = 5'(tot);
            q.push_back(e);
        end
        bus.inputMoney = v.in;
        bus.valueToPay = v.price;
        bus.mainState  = v.ms;
        @(posedge clock); #1;
        chk("load_rem", bus.remaining, v.total);
        chk("load_state", bus.changeState, 1);
        if (v.newin != 0) bus.inputMoney = v.newin;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 12) begin
            @(posedge clock); #1;
            cyc++;
            seen = bus.noMoneyLeft;
        end
        chk("nml_latency", cyc, v.n + 2);
        chk("nml_high", bus.noMoneyLeft, 1);
        chk("queue_empty", q.size(), 0);
        chk("done_rem", bus.remaining, 0);
        chk("done_state", bus.changeState, 2);
        repeat (3) @(posedge clock);
        #1;
        chk("nml_hold", bus.noMoneyLeft, 1);
        bus.mainState = MS_THANKS;
        @(posedge clock); #1;
        chk("thanks_nml", bus.noMoneyLeft, 0);
        chk("thanks_state", bus.changeState, 0);
        bus.mainState = MS_WAIT;
        q.delete();
        @(posedge clock); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, bus.changeState, 0);
        chk({tag, "_nml"}, bus.noMoneyLeft, 0);
        chk({tag, "_valid"}, bus.coinValid, 0);
        chk({tag, "_coin"}, bus.coinOut, 0);
        chk({tag, "_rem"}, bus.remaining, 0);
    endtask

    initial begin
        exp_t e;
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        bus.mainState  = MS_WAIT;
        bus.inputMoney = '0;
        bus.valueToPay = '0;

        tbl[0] = mk(MS_VALID,   28,  2,  0, 26, 4, 10, 10, 5, 1);
        tbl[1] = mk(MS_INVALID,  7,  3,  0,  7, 2,  5,  2, 0, 0);
        tbl[2] = mk(MS_VALID,   10, 10,  0,  0, 0,  0,  0, 0, 0);
        tbl[3] = mk(MS_VALID,   10, 20,  0,  0, 0,  0,  0, 0, 0);
        tbl[4] = mk(MS_VALID,   31,  0,  0, 31, 4, 10, 10, 10, 1);
        tbl[5] = mk(MS_INVALID,  0,  0,  0,  0, 0,  0,  0, 0, 0);
        tbl[6] = mk(MS_VALID,   19,  0,  0, 19, 4, 10,  5, 2, 2);
        tbl[7] = mk(MS_VALID,   20,  0, 30, 20, 2, 10, 10, 0, 0);

        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clock); #1;
        chk("idle_hold", bus.changeState, 0);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset after first coin of a 29-euro payout
        e.coin = 5'd10;
        e.rem  = 5'd19;
        q.push_back(e);
        bus.inputMoney = 5'd30;
        bus.valueToPay = 5'd1;
        bus.mainState  = MS_VALID;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_first_coin", bus.coinValid, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_zero("midrst");
        chk("rst_queue", q.size(), 0);
        reset = 1'b0;
        bus.mainState = MS_WAIT;
        @(posedge clock); #1;

        // Main machine drops out of payout states mid-PAY
        e.coin = 5'd10;
        e.rem  = 5'd10;
        q.push_back(e);
        bus.inputMoney = 5'd20;
        bus.valueToPay = 5'd0;
        bus.mainState  = MS_VALID;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_first_coin", bus.coinValid, 1);
        bus.mainState = MS_WAIT;
        @(posedge clock); #1;
        check_zero("abort");
        repeat (3) @(posedge clock);
        #1;
        chk("abort_no_nml", bus.noMoneyLeft, 0);
        chk("abort_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the main vending state machine (the block that drives mainState 0..4).
- When the main machine enters "invalid money" (2), returns the whole inserted amount; when it enters "valid money" (3), returns the change (inputMoney − valueToPay).
- Pays out one coin per clock using greedy denomination selection, then asserts noMoneyLeft. The main machine consumes noMoneyLeft to advance to its state 4.

Parameters:
- DEN0, 10, largest denomination (euros)
- DEN1, 5, second denomination
- DEN2, 2, third denomination
- DEN3, 1, smallest denomination; must be 1 so any amount is payable
- W, 5, money bus width (matches inputMoney/valueToPay)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears block on the rising edge where asserted
- mainState  in  3  main machine state: 0 wait, 1 inserted, 2 invalid, 3 valid, 4 thanks
- inputMoney  in  W  amount inserted by user
- valueToPay  in  W  product price
- noMoneyLeft  out  1  registered; high while payout complete and main still in 2/3
- coinValid  out  1  registered one-cycle pulse per dispensed coin
- coinOut  out  W  denomination of the current coin; 0 when coinValid=0
- remaining  out  W  amount still to be paid out
- changeState  out  2  internal state, for debug/display

Behaviour:
- Reset: changeState=IDLE(0), noMoneyLeft=0, coinValid=0, coinOut=0, remaining=0. Reset overrides every other condition, including mid-payout.
- IDLE(0):
  - If mainState==3: remaining<=inputMoney−valueToPay, saturated to 0 if valueToPay>inputMoney. Go to PAY.
  - If mainState==2: remaining<=inputMoney. Go to PAY.
  - Otherwise hold.
- PAY(1): each cycle one step.
  - remaining==0: noMoneyLeft<=1, coinValid<=0, coinOut<=0, go to DONE.
  - Otherwise: d = largest DENi ≤ remaining. coinValid<=1, coinOut<=d, remaining<=remaining−d, stay in PAY.
- DONE(2):
  - Hold noMoneyLeft=1 while mainState∈{2,3}.
  - When mainState is anything else (normally 4): noMoneyLeft<=0, remaining<=0, go to IDLE.
  - A fresh payout therefore cannot start until the main machine has left 2/3.
- Abort: if mainState∉{2,3} while in PAY, coinValid<=0, coinOut<=0, remaining<=0, go to IDLE. No noMoneyLeft pulse.
- Latency:
  - Main enters 3 at edge k; load at edge k+1; first coin visible after edge k+2.
  - N coins → noMoneyLeft high after edge k+N+2.
  - Zero change → no coins; noMoneyLeft high after edge k+2.
- Arithmetic:
  - All money unsigned W bits; subtraction is computed W+1 wide to detect the borrow.
  - remaining never wraps.
  - Greedy selection with DEN3=1 always terminates; max payout 31 = 10,10,10,1 (4 coins).
- Inputs inputMoney/valueToPay are sampled only in IDLE; later changes do not affect an active payout.
- coinOut is held at 0 when coinValid=0.
- changeState value 3 is unused; if reached, go to IDLE.

Decomposition:
- Shared package `vending_pkg`:
  - main-state encodings (MS_WAIT=0, MS_INSERTED=1, MS_INVALID=2, MS_VALID=3, MS_THANKS=4)
  - change-state encodings (CS_IDLE, CS_PAY, CS_DONE)
  - default denominations and money width
- One sub-module, `coin_selector`: purely combinational, takes remaining and the parameters, returns the chosen denomination d.
- `change_dispenser` is the FSM, registers and subtraction around it.

Test Plan:
- Valid, 28 in / price 2: mainState=3 → coins 10,10,5,1 on 4 consecutive cycles, remaining 26→16→6→1→0, then noMoneyLeft=1. Set mainState=4 → noMoneyLeft=0, IDLE.
- Invalid, 7 in: mainState=2 → coins 5,2, then noMoneyLeft=1 on the third cycle after load, held until mainState=4.
- Exact payment, 10 in / price 10, mainState=3 → no coinValid pulse; noMoneyLeft=1 two edges after mainState=3.
- Underflow guard, 10 in / price 20 forced with mainState=3 → remaining=0, no coins, noMoneyLeft=1.
- Abort/reset: 30 in / price 1, reset asserted after the first coin → next edge all outputs 0, IDLE. Separately, mainState forced to 0 mid-PAY → IDLE with no noMoneyLeft.
- Input change mid-payout: inputMoney changed from 20 to 30 during PAY → coin sequence unchanged from the originally loaded amount.
